// File: rtl/nios_mul_pkg.sv
// Shared types and pass tables for the nios_mul_seq multiply sequencer.
package nios_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULXUU = 2'b01,
    MULXSU = 2'b10,
    MULXSS = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } seq_state_e;

  // Bit 1 selects the high half of src1, bit 0 the high half of src2.
  typedef enum logic [1:0] {
    LL = 2'b00,
    LH = 2'b01,
    HL = 2'b10,
    HH = 2'b11
  } pass_e;

  localparam logic [2:0] N_MUL  = 3'd3;
  localparam logic [2:0] N_MULX = 3'd4;

  function automatic logic [5:0] pass_shift(input pass_e p);
    case (p)
      LL:      return 6'd0;
      LH, HL:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [2:0] pass_count(input mul_op_e o);
    return (o == MUL) ? N_MUL : N_MULX;
  endfunction

endpackage

// File: rtl/nios_mul_acc.sv
// 64-bit shift-accumulate of returned partial products plus signed correction
// and result selection for nios_mul_seq.
import nios_mul_pkg::*;

module nios_mul_acc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        add_en,
  input  pass_e       pass,
  input  logic [31:0] cell_p,
  input  logic        load_res,
  input  logic        load_zero,
  input  mul_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic [63:0] acc_p0;
  logic [63:0] sum;

  // Unsigned product high word corrected into the signed interpretation;
  // every term wraps at 32 bits.
  function automatic logic [31:0] select_result(
    input mul_op_e            f_op,
    input logic        [63:0] f_prod,
    input logic signed [31:0] f_a,
    input logic signed [31:0] f_b
  );
    logic [31:0] hi;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    hi     = f_prod[63:32];
    corr_a = (f_a < 32'sd0) ? 32'(f_b) : 32'd0;
    corr_b = (f_b < 32'sd0) ? 32'(f_a) : 32'd0;
    case (f_op)
      MUL:     return f_prod[31:0];
      MULXUU:  return hi;
      MULXSU:  return hi - corr_a;
      default: return hi - corr_a - corr_b;
    endcase
  endfunction

  assign sum = acc_p0 + ({32'd0, cell_p} << pass_shift(pass));

  // accumulate stage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_p0 <= 64'd0;
    end else if (clr) begin
      acc_p0 <= 64'd0;
    end else if (add_en) begin
      acc_p0 <= sum;
    end
  end

  // result stage: loaded from the sum that includes the final product
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result <= 32'd0;
    end else if (load_zero) begin
      result <= 32'd0;
    end else if (load_res) begin
      result <= select_result(op, sum, a, b);
    end
  end

endmodule

// File: rtl/nios_mul_seq.sv
// Sequencer driving a shared 16x16 registered multiply cell for MUL/MULX ops.
// Optional build macro: NIOS_MUL_SEQ_ZERO_SKIP_EN (zero operand short-cut).
import nios_mul_pkg::*;

module nios_mul_seq #(
  parameter int CELL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [15:0] cell_a,
  output logic [15:0] cell_b,
  output logic        cell_en,
  input  logic [31:0] cell_p
);

  seq_state_e  state;
  seq_state_e  state_next;
  mul_op_e     op_lat;
  logic [31:0] src1_lat;
  logic [31:0] src2_lat;
  pass_e       pass;
  logic [1:0]  pass_inc;
  logic        accept;
  logic        last_issue;
  logic        zero_skip;

  logic        vld_p0;
  logic        last_p0;
  pass_e       pass_p0;
  logic        vld_p1;
  logic        last_p1;
  pass_e       pass_p1;
  logic        arr_vld;
  logic        arr_last;
  pass_e       arr_pass;
  logic        final_arr;

`ifdef NIOS_MUL_SEQ_ZERO_SKIP_EN
  assign zero_skip = (req_src1 == 32'd0) || (req_src2 == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  assign pass_inc = pass + 2'd1;

  // Operand halves follow the pass counter; both freeze outside ISSUE.
  assign cell_a = pass[1] ? src1_lat[31:16] : src1_lat[15:0];
  assign cell_b = pass[0] ? src2_lat[31:16] : src2_lat[15:0];

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    cell_en    = 1'b0;
    accept     = 1'b0;
    last_issue = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !abort) begin
          accept     = 1'b1;
          state_next = zero_skip ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        cell_en = 1'b1;
        if ((3'({1'b0, pass}) + 3'd1) == pass_count(op_lat)) begin
          last_issue = 1'b1;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (final_arr) begin
          state_next = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pass     <= LL;
      op_lat   <= MUL;
      src1_lat <= 32'd0;
      src2_lat <= 32'd0;
    end else if (accept) begin
      pass     <= LL;
      op_lat   <= mul_op_e'(req_op);
      src1_lat <= req_src1;
      src2_lat <= req_src2;
    end else if (cell_en && !last_issue && !abort) begin
      pass <= pass_e'(pass_inc);
    end
  end

  // arrival pipeline: p0 marks products one cycle after issue, p1 two cycles
  always_ff @(posedge clk) begin
    if (!reset_n || abort) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p0  <= cell_en;
      last_p0 <= last_issue;
      vld_p1  <= vld_p0;
      last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clk) begin
    pass_p0 <= pass;
    pass_p1 <= pass_p0;
  end

  assign arr_vld   = (CELL_LAT == 2) ? vld_p1  : vld_p0;
  assign arr_last  = (CELL_LAT == 2) ? last_p1 : last_p0;
  assign arr_pass  = (CELL_LAT == 2) ? pass_p1 : pass_p0;
  assign final_arr = arr_vld && arr_last;

  nios_mul_acc u_acc (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (accept),
    .add_en    (arr_vld && !abort),
    .pass      (arr_pass),
    .cell_p    (cell_p),
    .load_res  ((state == DRAIN) && final_arr && !abort),
    .load_zero (accept && zero_skip),
    .op        (op_lat),
    .a         (src1_lat),
    .b         (src2_lat),
    .result    (rsp_result)
  );

endmodule

// File: tb/tb_nios_mul_seq.sv
// Self-checking bench for nios_mul_seq with a behavioural registered 16x16 cell.
module tb_nios_mul_seq;

  localparam int CELL_LAT = 1;
`ifdef NIOS_MUL_SEQ_ZERO_SKIP_EN
  localparam bit ZSKIP = 1'b1;
`else
  localparam bit ZSKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = 32'd0;
  logic [31:0] req_src2 = 32'd0;
  logic        abort = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [15:0] cell_a;
  logic [15:0] cell_b;
  logic        cell_en;
  logic [31:0] cell_p;

  int checks = 0;
  int errors = 0;

  logic [15:0] cap_a [0:7];
  logic [15:0] cap_b [0:7];

  logic [31:0] r;
  int          lat, ec, ef, el;
  bit          to, hold, rdy;

  always #5 clk = ~clk;

  nios_mul_seq #(.CELL_LAT(CELL_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .abort      (abort),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .cell_a     (cell_a),
    .cell_b     (cell_b),
    .cell_en    (cell_en),
    .cell_p     (cell_p)
  );

  // behavioural multiply cell: enable-gated first stage, free-running second
  logic [31:0] cell_s0 = 32'd0;
  logic [31:0] cell_s1 = 32'd0;
  always @(posedge clk) begin
    if (cell_en) cell_s0 <= cell_a * cell_b;
    cell_s1 <= cell_s0;
  end
  assign cell_p = (CELL_LAT == 2) ? cell_s1 : cell_s0;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (op[1]) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (op == 2'b11) ? longint'($signed(b)) : longint'({32'd0, b});
    p = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (ZSKIP && (a == 32'd0 || b == 32'd0)) return 1;
    return ((op == 2'b00) ? 3 : 4) + 1 + CELL_LAT;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom();
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int stall,
                        output logic [31:0] res, output int l, output int en_cnt, output int en_first,
                        output int en_last, output bit tmo, output bit hold_ok, output bit rdy_after);
    int  w;
    bit  hs_ready;
    tmo = 0; hold_ok = 1; rdy_after = 0; res = 32'd0; l = -1;
    en_cnt = 0; en_first = -1; en_last = -1; w = 0;
    tick();
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      tick();
      @(negedge clk);
      w++;
    end
    if (!req_ready) tmo = 1;
    tick();
    req_valid = 1'b0; req_op = 2'($urandom()); req_src1 = $urandom(); req_src2 = $urandom();
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (cell_en) begin
        if (en_cnt < 8) begin
          cap_a[en_cnt] = cell_a;
          cap_b[en_cnt] = cell_b;
        end
        if (en_first < 0) en_first = c;
        en_last = c;
        en_cnt++;
      end
      if (rsp_valid) begin
        l = c;
        break;
      end
      tick();
    end
    if (l < 0) begin
      tmo = 1;
      tick(); abort = 1'b1;
      tick(); abort = 1'b0;
      return;
    end
    res = rsp_result;
    for (int s = 0; s < stall; s++) begin
      tick();
      @(negedge clk);
      if (!rsp_valid || rsp_result !== res || req_ready) hold_ok = 0;
    end
    tick(); rsp_ready = 1'b1;
    @(negedge clk);
    hs_ready = req_ready;
    tick(); rsp_ready = 1'b0;
    @(negedge clk);
    rdy_after = !hs_ready && req_ready && !rsp_valid;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
    checks++; if (cell_en !== 1'b0) begin errors++; $display("FAIL reset_cell_en got %b want 0", cell_en); end
    checks++; if (cell_a !== 16'd0) begin errors++; $display("FAIL reset_cell_a got %h want 0", cell_a); end
    checks++; if (cell_b !== 16'd0) begin errors++; $display("FAIL reset_cell_b got %h want 0", cell_b); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [15:0] ea [0:2];
    logic [15:0] eb [0:2];
    ea[0] = 16'd3; ea[1] = 16'd3; ea[2] = 16'd1;
    eb[0] = 16'd5; eb[1] = 16'd2; eb[2] = 16'd5;
    run_op(2'b00, 32'h0001_0003, 32'h0002_0005, 0, r, lat, ec, ef, el, to, hold, rdy);
    checks++; if (to) begin errors++; $display("FAIL mul_timeout got 1 want 0"); end
    checks++; if (r !== 32'h000B_000F) begin errors++; $display("FAIL mul_result got %h want 000b000f", r); end
    checks++; if (lat != 4 + CELL_LAT) begin errors++; $display("FAIL mul_latency got %0d want %0d", lat, 4 + CELL_LAT); end
    checks++; if (ec != 3 || ef != 1 || el != 3) begin
      errors++; $display("FAIL mul_cell_en_window got cnt %0d first %0d last %0d want 3 1 3", ec, ef, el);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap_a[i] !== ea[i] || cap_b[i] !== eb[i]) begin
        errors++; $display("FAIL mul_pair%0d got (%h,%h) want (%h,%h)", i, cap_a[i], cap_b[i], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_mulx();
    logic [1:0]  ops [0:3];
    logic [31:0] as  [0:3];
    logic [31:0] bs  [0:3];
    logic [31:0] es  [0:3];
    ops[0] = 2'b01; as[0] = 32'hFFFF_FFFF; bs[0] = 32'hFFFF_FFFF; es[0] = 32'hFFFF_FFFE;
    ops[1] = 2'b11; as[1] = 32'hFFFF_FFFF; bs[1] = 32'h0000_0002; es[1] = 32'hFFFF_FFFF;
    ops[2] = 2'b10; as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; es[2] = 32'h8000_0000;
    ops[3] = 2'b11; as[3] = 32'h8000_0000; bs[3] = 32'h8000_0000; es[3] = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], 0, r, lat, ec, ef, el, to, hold, rdy);
      checks++; if (to) begin errors++; $display("FAIL mulx%0d_timeout got 1 want 0", i); end
      checks++; if (r !== es[i]) begin errors++; $display("FAIL mulx%0d_result got %h want %h", i, r, es[i]); end
      checks++; if (lat != 5 + CELL_LAT) begin errors++; $display("FAIL mulx%0d_latency got %0d want %0d", i, lat, 5 + CELL_LAT); end
      checks++; if (ec != 4) begin errors++; $display("FAIL mulx%0d_passes got %0d want 4", i, ec); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      run_op(op, a, b, 0, r, lat, ec, ef, el, to, hold, rdy);
      checks++;
      if (to || r !== ref_mul(op, a, b)) begin
        errors++; $display("FAIL rand%0d_result op %0d a %h b %h got %h want %h", i, op, a, b, r, ref_mul(op, a, b));
      end
      checks++;
      if (lat != exp_lat(op, a, b)) begin
        errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, exp_lat(op, a, b));
      end
    end
  endtask

  task automatic test_backpressure();
    run_op(2'b10, 32'hDEAD_BEEF, 32'h1234_5678, 4, r, lat, ec, ef, el, to, hold, rdy);
    checks++; if (r !== ref_mul(2'b10, 32'hDEAD_BEEF, 32'h1234_5678)) begin
      errors++; $display("FAIL bp_result got %h want %h", r, ref_mul(2'b10, 32'hDEAD_BEEF, 32'h1234_5678));
    end
    checks++; if (!hold) begin errors++; $display("FAIL bp_hold got 0 want 1"); end
    checks++; if (!rdy) begin errors++; $display("FAIL bp_ready_after_release got 0 want 1"); end
  endtask

  task automatic test_abort();
    tick();
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
    tick();
    req_valid = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 3; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if (cell_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL abort_cycle%0d got en %b rdy %b vld %b want 0 1 0", c, cell_en, req_ready, rsp_valid);
      end
      tick();
    end
    run_op(2'b00, 32'h0000_0007, 32'h0000_0006, 0, r, lat, ec, ef, el, to, hold, rdy);
    checks++; if (to || r !== 32'h0000_002A) begin errors++; $display("FAIL abort_next_result got %h want 0000002a", r); end
    tick();
    req_valid = 1'b1; abort = 1'b1; req_op = 2'b11; req_src1 = 32'h0000_0003; req_src2 = 32'h0000_0004;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++;
    if (cell_en !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_idle got en %b rdy %b want 0 1", cell_en, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    req_valid = 1'b1; req_op = 2'b11; req_src1 = 32'h1357_9BDF; req_src2 = 32'h2468_ACE0;
    tick();
    req_valid = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || cell_en !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl got rdy %b vld %b en %b want 1 0 0", req_ready, rsp_valid, cell_en);
    end
    checks++;
    if (rsp_result !== 32'd0 || cell_a !== 16'd0 || cell_b !== 16'd0) begin
      errors++; $display("FAIL rstmid_data got res %h a %h b %h want 0 0 0", rsp_result, cell_a, cell_b);
    end
    run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0003, 0, r, lat, ec, ef, el, to, hold, rdy);
    checks++; if (to || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rstmid_next got %h want ffffffff", r); end
  endtask

  task automatic test_zero();
    run_op(2'b11, 32'd0, 32'h1234_5678, 0, r, lat, ec, ef, el, to, hold, rdy);
    checks++; if (to || r !== 32'd0) begin errors++; $display("FAIL zero_result got %h want 0", r); end
    checks++; if (lat != (ZSKIP ? 1 : 5 + CELL_LAT)) begin
      errors++; $display("FAIL zero_latency got %0d want %0d", lat, ZSKIP ? 1 : 5 + CELL_LAT);
    end
    checks++; if (ec != (ZSKIP ? 0 : 4)) begin errors++; $display("FAIL zero_passes got %0d want %0d", ec, ZSKIP ? 0 : 4); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulx();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
